// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the access-legality rule used by the top level.
package datamem_pkg;

    localparam int unsigned LATENCY_MAX = 15;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dm_state_t;

    // True for an unsupported funct3 or a halfword/word access off its natural boundary.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = (f3 > F3_W);
        end else begin
            illegal = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                     ((f3[1:0] == 2'b10) && (lane != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/datamem_array.sv
// Word-organised data RAM: 2^ADDR_W x 32, per-byte write enables,
// synchronous registered read.
module datamem_array #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // NOTE: the storage array is deliberately not reset; contents survive reset
    // and a reset loop over every word would prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/datamem_responder.sv
// Data-memory responder: serves core loads/stores against a word RAM with
// LATENCY wait states, byte/halfword lane handling and fault reporting.
module datamem_responder
    import datamem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Stall,
    output logic        Fault
);

    localparam logic [3:0]  LAT_CNT = LATENCY[3:0];
    localparam int unsigned AW_B    = ADDR_W + 2;

    dm_state_t       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW_B-1:0] addr_q, addr_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            store_q, store_d;

    logic            req;
    logic            commit;
    logic            op_store;
    logic [2:0]      op_f3;
    logic [AW_B-1:0] op_addr;
    logic [31:0]     op_wdata;
    logic            op_fault;
    logic [3:0]      ram_we;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;
    logic            done_fault;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic            unused_addr_hi;

    assign req            = MemRead | MemWrite;
    assign unused_addr_hi = ^Addr[31:AW_B];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        f3_q    <= f3_d;
        wdata_q <= wdata_d;
        store_q <= store_d;
    end

    // Capture the request once in IDLE; later input changes are ignored.
    always_comb begin
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        store_d = store_q;
        if (state_q == ST_IDLE && req) begin
            addr_d  = Addr[AW_B-1:0];
            f3_d    = Funct3;
            wdata_d = WrData;
            store_d = MemWrite;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (LATENCY == 0) ? ST_DONE : ST_ACCESS;
                    cnt_d   = LAT_CNT;
                end
            end
            ST_ACCESS: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // With zero wait states the RAM is touched straight from IDLE, before capture.
    always_comb begin
        op_store = store_q;
        op_f3    = f3_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            op_store = MemWrite;
            op_f3    = Funct3;
            op_addr  = Addr[AW_B-1:0];
            op_wdata = WrData;
        end
    end

    assign commit   = !reset && req &&
                      ((state_q == ST_IDLE && LATENCY == 0) ||
                       (state_q == ST_ACCESS && cnt_q == 4'd1));
    assign op_fault = access_fault(op_store, op_f3, op_addr[1:0]);

    always_comb begin
        ram_we    = '0;
        ram_wdata = op_wdata;
        case (op_f3)
            F3_B: begin
                ram_wdata = {4{op_wdata[7:0]}};
                ram_we    = 4'b0001 << op_addr[1:0];
            end
            F3_H: begin
                ram_wdata = {2{op_wdata[15:0]}};
                ram_we    = op_addr[1] ? 4'b1100 : 4'b0011;
            end
            F3_W:    ram_we = 4'b1111;
            default: ram_we = '0;
        endcase
        if (!(commit && op_store) || op_fault) begin
            ram_we = '0;
        end
    end

    datamem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (commit),
        .we    (ram_we),
        .addr  (op_addr[AW_B-1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign done_fault = access_fault(store_q, f3_q, addr_q[1:0]);
    assign rd_byte    = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half    = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        Stall  = 1'b0;
        Fault  = 1'b0;
        RdData = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE:   Stall = req;
                ST_ACCESS: Stall = 1'b1;
                ST_DONE: begin
                    Fault = done_fault;
                    if (!store_q && !done_fault) begin
                        case (f3_q)
                            F3_B:    RdData = {{24{rd_byte[7]}}, rd_byte};
                            F3_H:    RdData = {{16{rd_half[15]}}, rd_half};
                            F3_W:    RdData = ram_rdata;
                            F3_BU:   RdData = {24'd0, rd_byte};
                            F3_HU:   RdData = {16'd0, rd_half};
                            default: RdData = '0;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_responder.sv
// Self-checking bench for datamem_responder: one instance with two wait
// states, one with none, each compared against a word-array reference model.
module tb_datamem_responder;

    localparam int unsigned AW    = 9;
    localparam int unsigned WORDS = 2**AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rd_a, wr_a, stall_a, fault_a;
    logic [2:0]  f3_a;
    logic [31:0] addr_a, wd_a, rdata_a;
    logic        rd_z, wr_z, stall_z, fault_z;
    logic [2:0]  f3_z;
    logic [31:0] addr_z, wd_z, rdata_z;

    datamem_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset), .MemRead(rd_a), .MemWrite(wr_a), .Funct3(f3_a),
        .Addr(addr_a), .WrData(wd_a), .RdData(rdata_a), .Stall(stall_a), .Fault(fault_a)
    );

    datamem_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset), .MemRead(rd_z), .MemWrite(wr_z), .Funct3(f3_z),
        .Addr(addr_z), .WrData(wd_z), .RdData(rdata_z), .Stall(stall_z), .Fault(fault_z)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory per instance (0: two wait states, 1: zero wait states).
    logic [31:0] mdl    [2][WORDS];
    bit          mvalid [2][WORDS];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit model_fault(input bit st, input int f3, input int lo);
        bit bad_code;
        int size;
        if (st) bad_code = (f3 > 2);
        else    bad_code = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        size = f3 % 4;
        return bad_code || (size == 1 && (lo % 2) != 0) || (size == 2 && lo != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input int f3, input int lo);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> (8 * lo);
        r  = 32'd0;
        case (f3)
            0: begin r = sh & 32'hFF;   if (r >= 32'h80)   r = r | 32'hFFFF_FF00; end
            1: begin r = sh & 32'hFFFF; if (r >= 32'h8000) r = r | 32'hFFFF_0000; end
            2: r = word;
            4: r = sh & 32'hFF;
            5: r = sh & 32'hFFFF;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input int f3,
                                                input int lo, input logic [31:0] wd);
        logic [31:0] size_mask;
        logic [31:0] mask;
        size_mask = (f3 == 0) ? 32'hFF : (f3 == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask      = size_mask << (8 * lo);
        return (old & ~mask) | (((wd & size_mask) << (8 * lo)) & mask);
    endfunction

    task automatic drive(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (d == 0) begin
            rd_a = rd; wr_a = wr; f3_a = f3; addr_a = addr; wd_a = wd;
        end else begin
            rd_z = rd; wr_z = wr; f3_z = f3; addr_z = addr; wd_z = wd;
        end
    endtask

    // Presents one request, holds it while Stall is high, samples the DONE cycle.
    task automatic do_access(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rdata, output logic fault, output int stalls);
        logic s;
        @(posedge clk); #1;
        drive(d, rd, wr, f3, addr, wd);
        stalls = 0;
        s = 1'b1;
        while (s && stalls <= 40) begin
            @(negedge clk);
            s = (d == 0) ? stall_a : stall_z;
            if (s) stalls++;
        end
        rdata = (d == 0) ? rdata_a : rdata_z;
        fault = (d == 0) ? fault_a : fault_z;
        drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // One transaction scored against the reference model.
    task automatic run_op(input string name, input int d, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata);
        int          idx, lo, stalls;
        bit          st, flt, known;
        logic [31:0] exp_data;
        logic        got_fault;
        idx      = int'(addr[AW+1:2]);
        lo       = int'(addr[1:0]);
        st       = wr;
        flt      = model_fault(st, int'(f3), lo);
        known    = st || flt || mvalid[d][idx];
        exp_data = (st || flt) ? 32'd0 : model_load(mdl[d][idx], int'(f3), lo);
        do_access(d, rd, wr, f3, addr, wd, rdata, got_fault, stalls);
        checks++;
        if (stalls != lat_of(d) + 1) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, lat_of(d) + 1);
        end
        checks++;
        if (got_fault !== flt) begin
            errors++;
            $display("FAIL %s fault: got %b expected %b", name, got_fault, flt);
        end
        if (known) begin
            checks++;
            if (rdata !== exp_data) begin
                errors++;
                $display("FAIL %s rddata: got %h expected %h", name, rdata, exp_data);
            end
        end
        if (st && !flt) begin
            mdl[d][idx]    = model_store(mdl[d][idx], int'(f3), lo, wd);
            mvalid[d][idx] = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        drive(1, 1'b0, 1'b1, 3'd2, 32'h10, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_a !== 1'b0 || stall_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b/%b expected 0/0", stall_a, stall_z);
        end
        checks++;
        if (rdata_a !== 32'd0 || rdata_z !== 32'd0) begin
            errors++;
            $display("FAIL reset_rddata: got %h/%h expected 0", rdata_a, rdata_z);
        end
        checks++;
        if (fault_a !== 1'b0 || fault_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault: got %b/%b expected 0/0", fault_a, fault_z);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (stall_a !== 1'b0 || fault_a !== 1'b0 || rdata_a !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got stall %b fault %b data %h expected 0", stall_a, fault_a, rdata_a);
        end
    endtask

    task automatic test_word();
        logic [31:0] r;
        run_op("sw_deadbeef", 0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, r);
        run_op("lw_deadbeef", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, r);
        checks++;
        if (r !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lw_const: got %h expected deadbeef", r);
        end
    endtask

    task automatic test_byte();
        logic [31:0] r;
        run_op("sw_zero", 0, 1'b0, 1'b1, 3'd2, 32'h10, 32'd0, r);
        run_op("sb_80", 0, 1'b0, 1'b1, 3'd0, 32'h11, 32'hABCD_EF80, r);
        run_op("lw_after_sb", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, r);
        checks++;
        if (r !== 32'h0000_8000) begin
            errors++;
            $display("FAIL sb_word: got %h expected 00008000", r);
        end
        run_op("lb_11", 0, 1'b1, 1'b0, 3'd0, 32'h11, 32'd0, r);
        checks++;
        if (r !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_const: got %h expected ffffff80", r);
        end
        run_op("lbu_11", 0, 1'b1, 1'b0, 3'd4, 32'h11, 32'd0, r);
        checks++;
        if (r !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_const: got %h expected 00000080", r);
        end
    endtask

    task automatic test_half();
        logic [31:0] r;
        run_op("sw_20", 0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h1234_5678, r);
        run_op("sh_8001", 0, 1'b0, 1'b1, 3'd1, 32'h22, 32'hFFFF_8001, r);
        run_op("lh_22", 0, 1'b1, 1'b0, 3'd1, 32'h22, 32'd0, r);
        checks++;
        if (r !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_const: got %h expected ffff8001", r);
        end
        run_op("lhu_22", 0, 1'b1, 1'b0, 3'd5, 32'h22, 32'd0, r);
        checks++;
        if (r !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu_const: got %h expected 00008001", r);
        end
        run_op("lw_20", 0, 1'b1, 1'b0, 3'd2, 32'h20, 32'd0, r);
        checks++;
        if (r !== 32'h8001_5678) begin
            errors++;
            $display("FAIL sh_word: got %h expected 80015678", r);
        end
    endtask

    task automatic test_fault();
        logic [31:0] r;
        run_op("lw_mis13", 0, 1'b1, 1'b0, 3'd2, 32'h13, 32'd0, r);
        @(negedge clk);
        checks++;
        if (fault_a !== 1'b0) begin
            errors++;
            $display("FAIL fault_pulse: got %b expected 0", fault_a);
        end
        run_op("sw_04", 0, 1'b0, 1'b1, 3'd2, 32'h04, 32'hCAFE_F00D, r);
        run_op("sh_mis05", 0, 1'b0, 1'b1, 3'd1, 32'h05, 32'h0000_1111, r);
        run_op("sb_illegal", 0, 1'b0, 1'b1, 3'd3, 32'h04, 32'h0000_2222, r);
        run_op("lw_04", 0, 1'b1, 1'b0, 3'd2, 32'h04, 32'd0, r);
        checks++;
        if (r !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL fault_nowrite: got %h expected cafef00d", r);
        end
        run_op("ld_f3_011", 0, 1'b1, 1'b0, 3'd3, 32'h10, 32'd0, r);
        run_op("both_strobes", 0, 1'b1, 1'b1, 3'd2, 32'h24, 32'h0F0F_0F0F, r);
    endtask

    task automatic test_abort();
        logic [31:0] r;
        run_op("sw_30", 0, 1'b0, 1'b1, 3'd2, 32'h30, 32'h55AA_55AA, r);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 3'd2, 32'h30, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_a !== 1'b0 || fault_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got stall %b fault %b expected 0 0", stall_a, fault_a);
        end
        run_op("lw_after_abort", 0, 1'b1, 1'b0, 3'd2, 32'h30, 32'd0, r);
        checks++;
        if (r !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL abort_nowrite: got %h expected 55aa55aa", r);
        end
        // Reset on the last ACCESS cycle, where the store would otherwise commit.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 3'd2, 32'h30, 32'h0BAD_F00D);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %b expected 0", stall_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (stall_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: got %b expected 0", stall_a);
        end
        run_op("lw_after_reset", 0, 1'b1, 1'b0, 3'd2, 32'h30, 32'd0, r);
        checks++;
        if (r !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL reset_nowrite: got %h expected 55aa55aa", r);
        end
    endtask

    task automatic test_back_to_back_lat0();
        logic [31:0] r;
        run_op("z_sw_000", 1, 1'b0, 1'b1, 3'd2, 32'h000, 32'h0123_4567, r);
        run_op("z_lw_000", 1, 1'b1, 1'b0, 3'd2, 32'h000, 32'd0, r);
        run_op("z_sw_004", 1, 1'b0, 1'b1, 3'd2, 32'h004, 32'h89AB_CDEF, r);
        run_op("z_lw_004", 1, 1'b1, 1'b0, 3'd2, 32'h004, 32'd0, r);
        run_op("z_lw_wrap", 1, 1'b1, 1'b0, 3'd2, 32'h800, 32'd0, r);
        checks++;
        if (r !== 32'h0123_4567) begin
            errors++;
            $display("FAIL wrap_800: got %h expected 01234567", r);
        end
        run_op("z_lh_mis", 1, 1'b1, 1'b0, 3'd1, 32'h003, 32'd0, r);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] addr;
        logic [2:0]  f3;
        int          kind;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                run_op("rnd_init", d, 1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom, r);
            end
            for (int n = 0; n < 60; n++) begin
                kind = $urandom_range(0, 2);
                f3   = 3'($urandom_range(0, 7));
                addr = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 7)) << 11);
                run_op("rnd_op", d, kind != 1, kind != 0, f3, addr, $urandom, r);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_abort();
        test_back_to_back_lat0();
        test_random();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
